// File: rtl/bin_act_pack_if.sv
// rtl/bin_act_pack_if.sv - popcount beat input and packed word output handshake bundle
interface bin_act_pack_if #(
    parameter int PW = 7
);
    logic          pc_valid;
    logic [PW-1:0] pc_in;
    logic          pc_ready;
    logic [31:0]   out_data;
    logic [5:0]    out_bits;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output pc_valid, pc_in, out_ready,
        input  pc_ready, out_data, out_bits, out_valid
    );

    modport slave (
        input  pc_valid, pc_in, out_ready,
        output pc_ready, out_data, out_bits, out_valid
    );
endinterface

// File: rtl/bin_act_pack.sv
// rtl/bin_act_pack.sv - sums popcount groups, thresholds to activation bits, packs 32-bit words
module bin_act_pack #(
    parameter int ACC_N = 4,
    parameter int PW    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               c_rst,
    input  logic [9:0]         thresh,
    input  logic               flush,
    bin_act_pack_if.slave      bus
);
    localparam logic [3:0] G_LAST = 4'(ACC_N - 1);

    logic [3:0]  gcnt;
    logic [9:0]  sum;
    logic [4:0]  bcnt;
    logic [31:0] pack;
    logic        flush_pending;
    logic [31:0] out_data_q;
    logic [5:0]  out_bits_q;
    logic        out_valid_q;

    logic [3:0]  n_gcnt;
    logic [9:0]  n_sum;
    logic [4:0]  n_bcnt;
    logic [31:0] n_pack;
    logic        n_fp;
    logic [31:0] n_data;
    logic [5:0]  n_bits;
    logic        n_valid;

    logic          buf_free;
    logic          grp_last;
    logic          word_last;
    logic          pc_ready;
    logic          beat;
    logic [PW-1:0] pc_val;
    logic [9:0]    sum_next;
    logic          act;
    logic [31:0]   pack_act;

    assign pc_val    = bus.pc_in;
    assign buf_free  = !out_valid_q || bus.out_ready;
    assign grp_last  = (gcnt == G_LAST);
    assign word_last = grp_last && (bcnt == 5'd31);
    // Stall only when the next beat or a pending flush would need a buffer that is still occupied
    assign pc_ready  = !((word_last || flush_pending) && !buf_free);
    assign beat      = bus.pc_valid && pc_ready;
    assign sum_next  = sum + 10'(pc_val);
    assign act       = (sum_next >= thresh);

    // Pack register with the current activation dropped into its slot
    always_comb begin
        pack_act       = pack;
        pack_act[bcnt] = act;
    end

    // Next-state: beat first, then flush against the post-beat pack state, buffer load beats a take
    always_comb begin
        n_gcnt  = gcnt;
        n_sum   = sum;
        n_bcnt  = bcnt;
        n_pack  = pack;
        n_fp    = flush_pending;
        n_data  = out_data_q;
        n_bits  = out_bits_q;
        n_valid = out_valid_q && !bus.out_ready;

        if (beat) begin
            if (grp_last) begin
                n_gcnt = '0;
                n_sum  = '0;
                if (bcnt == 5'd31) begin
                    n_data  = pack_act;
                    n_bits  = 6'd32;
                    n_valid = 1'b1;
                    n_pack  = '0;
                    n_bcnt  = '0;
                end else begin
                    n_pack = pack_act;
                    n_bcnt = bcnt + 5'd1;
                end
            end else begin
                n_sum  = sum_next;
                n_gcnt = gcnt + 4'd1;
            end
        end

        if (flush || flush_pending) begin
            if (buf_free) begin
                if (n_bcnt != 5'd0) begin
                    n_data  = n_pack;
                    n_bits  = {1'b0, n_bcnt};
                    n_valid = 1'b1;
                    n_pack  = '0;
                    n_bcnt  = '0;
                end
                n_gcnt = '0;
                n_sum  = '0;
                n_fp   = 1'b0;
            end else begin
                n_fp = 1'b1;
            end
        end
    end

    // State register: async reset, synchronous clear takes priority over all activity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt          <= '0;
            sum           <= '0;
            bcnt          <= '0;
            pack          <= '0;
            flush_pending <= 1'b0;
            out_data_q    <= '0;
            out_bits_q    <= '0;
            out_valid_q   <= 1'b0;
        end else if (c_rst) begin
            gcnt          <= '0;
            sum           <= '0;
            bcnt          <= '0;
            pack          <= '0;
            flush_pending <= 1'b0;
            out_data_q    <= '0;
            out_bits_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            gcnt          <= n_gcnt;
            sum           <= n_sum;
            bcnt          <= n_bcnt;
            pack          <= n_pack;
            flush_pending <= n_fp;
            out_data_q    <= n_data;
            out_bits_q    <= n_bits;
            out_valid_q   <= n_valid;
        end
    end

    assign bus.pc_ready  = pc_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bin_act_pack.sv
// tb/tb_bin_act_pack.sv - directed self-checking bench for bin_act_pack with a queue-based model
module tb_bin_act_pack;
    localparam int ACC_N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       c_rst = 1'b0;
    logic       flush = 1'b0;
    logic [9:0] thresh = 10'd100;

    always #5 clk = ~clk;

    bin_act_pack_if #(.PW(7)) bus();

    bin_act_pack #(.ACC_N(ACC_N), .PW(7)) dut (
        .clk    (clk),
        .rst    (rst),
        .c_rst  (c_rst),
        .thresh (thresh),
        .flush  (flush),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: beats in current group, running sum, queue of activation bits, one buffered word
    int          m_g;
    int          m_sum;
    bit          mq[$];
    bit          m_valid;
    logic [31:0] m_data;
    int          m_bits;
    bit          m_pend;

    function automatic bit m_rdy();
        bit free;
        bit need;
        free = !m_valid || bus.out_ready;
        need = ((m_g == ACC_N - 1) && (mq.size() == 31)) || m_pend;
        return !(need && !free);
    endfunction

    task automatic m_clear();
        m_g = 0; m_sum = 0; mq.delete();
        m_valid = 0; m_data = '0; m_bits = 0; m_pend = 0;
    endtask

    task automatic m_emit();
        m_data = '0;
        foreach (mq[i]) m_data[i] = mq[i];
        m_bits  = mq.size();
        m_valid = 1;
        mq.delete();
    endtask

    task automatic m_step();
        bit free;
        bit rdy;
        if (!rst || c_rst) begin
            m_clear();
            return;
        end
        free = !m_valid || bus.out_ready;
        rdy  = m_rdy();
        if (m_valid && bus.out_ready) m_valid = 0;
        if (bus.pc_valid && rdy) begin
            m_sum += int'(bus.pc_in);
            m_g++;
            if (m_g == ACC_N) begin
                mq.push_back(m_sum >= int'(thresh));
                m_g = 0;
                m_sum = 0;
                if (mq.size() == 32) m_emit();
            end
        end
        if (flush || m_pend) begin
            if (free) begin
                if (mq.size() > 0) m_emit();
                m_g = 0; m_sum = 0; m_pend = 0;
            end else begin
                m_pend = 1;
            end
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge rst);
            m_step();
        end
    end

    // Compare DUT against the model every falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("model_pc_ready", 32'(bus.pc_ready), 32'(m_rdy()));
            chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_out_data", bus.out_data, m_data);
                chk("model_out_bits", 32'(bus.out_bits), 32'(m_bits));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int v);
        int t;
        t = 0;
        bus.pc_valid = 1'b1;
        bus.pc_in    = 7'(v);
        @(negedge clk);
        while (!bus.pc_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("beat_timeout", 32'(t), 32'(0));
        @(posedge clk);
        #1;
        bus.pc_valid = 1'b0;
    endtask

    task automatic group4(input int a, input int b, input int c, input int d);
        beat(a); beat(b); beat(c); beat(d);
    endtask

    task automatic group_act(input bit a);
        if (a) group4(30, 30, 30, 30);
        else   group4(25, 25, 25, 24);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        bus.pc_valid  = 1'b0;
        bus.pc_in     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_bits", 32'(bus.out_bits), 32'd0);
        chk("rst_pc_ready", 32'(bus.pc_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Alternating 100/99 groups -> 0x55555555 on the edge of beat 128
        for (int g = 0; g < 32; g++) begin
            if (g % 2 == 0) group4(25, 25, 25, 25);
            else            group4(25, 25, 25, 24);
        end
        chk("pack_valid", 32'(bus.out_valid), 32'd1);
        chk("pack_data", bus.out_data, 32'h5555_5555);
        chk("pack_bits", 32'(bus.out_bits), 32'd32);
        tick(1);
        chk("pack_taken", 32'(bus.out_valid), 32'd0);

        // Backpressure over two words
        bus.out_ready = 1'b0;
        for (int g = 0; g < 32; g++) group_act(g % 2 == 0);
        for (int g = 0; g < 31; g++) group_act(1'b1);
        beat(30); beat(30); beat(30);
        bus.pc_valid = 1'b1;
        bus.pc_in    = 7'd30;
        repeat (4) begin
            @(negedge clk);
            chk("bp_pc_ready", 32'(bus.pc_ready), 32'd0);
            chk("bp_hold_data", bus.out_data, 32'h5555_5555);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        #2 bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.pc_ready), 32'd1);
        @(posedge clk);
        #1 bus.pc_valid = 1'b0;
        chk("bp_word2_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_word2_data", bus.out_data, 32'hFFFF_FFFF);
        chk("bp_word2_bits", 32'(bus.out_bits), 32'd32);
        tick(1);
        chk("bp_word2_taken", 32'(bus.out_valid), 32'd0);

        // Flush of a partial word and a discarded partial group
        for (int g = 0; g < 5; g++) group_act(1'b1);
        beat(30); beat(30);
        do_flush();
        chk("flush_valid", 32'(bus.out_valid), 32'd1);
        chk("flush_data", bus.out_data, 32'h0000_001F);
        chk("flush_bits", 32'(bus.out_bits), 32'd5);
        group_act(1'b0);
        do_flush();
        chk("flush_fresh_data", bus.out_data, 32'd0);
        chk("flush_fresh_bits", 32'(bus.out_bits), 32'd1);
        bus.out_ready = 1'b0;

        // Flush under stall
        group_act(1'b1); group_act(1'b0); group_act(1'b1);
        do_flush();
        repeat (3) begin
            @(negedge clk);
            chk("fstall_pc_ready", 32'(bus.pc_ready), 32'd0);
            chk("fstall_data", bus.out_data, 32'd0);
            chk("fstall_bits", 32'(bus.out_bits), 32'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("fstall_ready_free", 32'(bus.pc_ready), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("fstall_emit_data", bus.out_data, 32'h0000_0005);
        chk("fstall_emit_bits", 32'(bus.out_bits), 32'd3);
        chk("fstall_emit_ready", 32'(bus.pc_ready), 32'd1);

        // c_rst with buffered word and 10 packed bits; simultaneous beat ignored
        for (int g = 0; g < 10; g++) group_act(1'b1);
        c_rst = 1'b1;
        bus.pc_valid = 1'b1;
        bus.pc_in    = 7'd30;
        @(posedge clk);
        #1;
        c_rst = 1'b0;
        bus.pc_valid = 1'b0;
        chk("crst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("crst_out_bits", 32'(bus.out_bits), 32'd0);
        chk("crst_pc_ready", 32'(bus.pc_ready), 32'd1);
        bus.out_ready = 1'b1;
        group_act(1'b0);
        do_flush();
        chk("crst_after_data", bus.out_data, 32'd0);
        chk("crst_after_bits", 32'(bus.out_bits), 32'd1);
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-group with a held word
        beat(30); beat(30);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data", bus.out_data, 32'd0);
        chk("arst_out_bits", 32'(bus.out_bits), 32'd0);
        chk("arst_pc_ready", 32'(bus.pc_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.out_ready = 1'b1;
        group_act(1'b1);
        group_act(1'b0);
        do_flush();
        chk("arst_after_data", bus.out_data, 32'h0000_0001);
        chk("arst_after_bits", 32'(bus.out_bits), 32'd2);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/bin_act_pack.md
BIN_ACT_PACK -- requirements
Module: bin_act_pack

Interface
REQ-001 Parameter ACC_N, default 4, number of popcount beats summed per activation bit; legal range 1..16.
REQ-002 Parameter PW, default 7, popcount input width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 c_rst  input  1  synchronous clear, active-high.
REQ-006 pc_valid  input  1  popcount beat valid, from bin_mult stage.
REQ-007 pc_in  input  PW  popcount value, 0..49.
REQ-008 pc_ready  output  1  beat accepted on a clock edge where pc_valid && pc_ready.
REQ-009 thresh  input  10  activation threshold, sampled on the beat that completes a group.
REQ-010 flush  input  1  request to emit the partially packed word.
REQ-011 out_data  output  32  packed activation word, bit 0 = oldest activation.
REQ-012 out_bits  output  6  number of valid bits in out_data, 1..32.
REQ-013 out_valid  output  1  out_data/out_bits valid.
REQ-014 out_ready  input  1  consumer takes word on a clock edge where out_valid && out_ready.

Function
REQ-015 Internal state: group counter gcnt (0..ACC_N-1), 10-bit sum register, bit counter bcnt (0..31), 32-bit pack register, one output buffer (out_data/out_bits/out_valid), one flush_pending flag.
REQ-016 On an accepted beat: sum_next = sum + zero-extended pc_in. No saturation is needed, since 49*16 < 1024.
REQ-017 If gcnt < ACC_N-1 on an accepted beat: sum <= sum_next and gcnt increments.
REQ-018 If gcnt == ACC_N-1 on an accepted beat, the group completes:
- act = (sum_next >= thresh), unsigned compare.
- act is written to pack[bcnt].
- sum and gcnt return to 0.
REQ-019 When a group completes and bcnt < 31: bcnt increments.
REQ-020 When a group completes and bcnt == 31, a word completes:
- {pack with act inserted} loads the buffer, out_bits = 32, out_valid = 1.
- pack clears and bcnt returns to 0.
REQ-021 Buffer free = !out_valid || out_ready, evaluated in the same cycle.
REQ-022 A buffer load and a consumer take in the same cycle are legal; the new word replaces the taken word and there is no bubble.
REQ-023 pc_ready = 0 only when an accepted beat would complete a word, or when flush_pending is set, while the buffer is not free; otherwise pc_ready = 1. pc_ready is combinational from out_ready.
REQ-024 Word completion latency: out_valid rises on the clock edge that accepts the completing beat.
REQ-025 When flush is asserted, or flush_pending is set, and the buffer is free:
- If bcnt > 0 (after any same-cycle beat), the buffer loads pack with the unused upper bits zero and out_bits = bcnt; pack and bcnt clear.
- If bcnt == 0, nothing is emitted.
- In both cases sum and gcnt clear, discarding the partial group, and flush_pending clears.
REQ-026 flush while the buffer is not free sets flush_pending; pc_ready is held 0 until the flush is honoured.
REQ-027 flush in the same cycle as an accepted beat: the beat is processed first. If that beat completes a word, the word is emitted and the flush emits nothing further (bcnt == 0 afterwards).
REQ-028 A repeated flush while flush_pending is already set has no extra effect.
REQ-029 out_data and out_bits hold stable while out_valid && !out_ready.
REQ-030 Taking a word never alters the pack, sum or counter state.

Reset
REQ-031 rst low asynchronously forces:
- gcnt = 0, sum = 0, bcnt = 0, pack = 0, flush_pending = 0.
- out_data = 0, out_bits = 0, out_valid = 0.
REQ-032 While rst is low, pc_ready = 1 after reset settles; no beat is accepted.
REQ-033 rst deassertion takes effect at the next clock edge; the first beat can be accepted on that edge.
REQ-034 c_rst high at a clock edge has the same effect as rst, synchronously, and takes priority over beats, flush and out_ready.
REQ-035 Any buffered word is discarded by rst or c_rst, including mid-operation.

Verification
REQ-036 Reset: pulse rst low mid-group with out_valid = 1 -> all outputs 0 immediately, pc_ready = 1, the next word begins from bit 0.
REQ-037 Packing: ACC_N = 4, thresh = 100, groups alternating {25,25,25,25} (sum 100 -> act 1) and {25,25,25,24} (sum 99 -> act 0), 32 groups -> out_data = 0x55555555, out_bits = 32, on the edge accepting beat 128.
REQ-038 Backpressure: out_ready = 0, two full words streamed -> first word held stable, pc_ready = 0 at beat 256 until out_ready = 1, then the second word is loaded in the same cycle the first is taken.
REQ-039 Flush: 5 groups of act 1 plus 2 beats of a sixth group, then flush -> out_data = 0x0000001F, out_bits = 5; the next group starts with gcnt = 0 and sum = 0.
REQ-040 Flush under stall: buffer full, out_ready = 0, flush pulse -> pc_ready = 0 and no emit; when out_ready = 1, the partial word is emitted on that edge and pc_ready returns to 1.
REQ-041 c_rst mid-operation: after 10 bits packed and out_valid = 1, c_rst = 1 -> out_valid = 0, bcnt = 0 on that edge; a simultaneous pc_valid beat is ignored.
